// File: rtl/barrel_shift_pkg.sv
// Purpose: shared mode encoding for the pipelined barrel shifter and its stages.
// Latency: n/a (constants only).
// Backpressure: n/a.
package barrel_shift_pkg;

  // Width of the shift-mode field carried alongside every word.
  localparam int MODE_W = 3;

  // Shift modes; codes above MODE_SRA are pass-through.
  localparam logic [MODE_W-1:0] MODE_ROL = 3'b000;
  localparam logic [MODE_W-1:0] MODE_ROR = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SLL = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SRL = 3'b011;
  localparam logic [MODE_W-1:0] MODE_SRA = 3'b100;

endpackage

// File: rtl/shift_stage_pipe.sv
// Purpose: one barrel-shifter stage, shifting by DIST when its amount bit is set.
// Latency: 1 cycle when REG = 1, combinational when REG = 0.
// Backpressure: register loads only while advance_i is high, otherwise holds.
module shift_stage_pipe
  import barrel_shift_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  DIST   = 1,
  parameter bit  REG    = 1'b1,
  localparam int AMT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              advance_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [AMT_W-1:0]  amt_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [AMT_W-1:0]  amt_o,
  output logic [MODE_W-1:0] mode_o
);

  // Amount bit that enables this stage (DIST is always a power of two).
  localparam int SEL = $clog2(DIST);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;
  logic [AMT_W-1:0]  amt_q;
  logic [MODE_W-1:0] mode_q;
  logic              valid_q;

  // Shift by DIST for the selected mode. For SRA the incoming MSB is the
  // original sign: every earlier stage has already replicated it.
  always_comb begin
    data_d = data_i;
    if (amt_i[SEL]) begin
      case (mode_i)
        MODE_ROL: data_d = {data_i[DATA_W-DIST-1:0], data_i[DATA_W-1:DATA_W-DIST]};
        MODE_ROR: data_d = {data_i[DIST-1:0], data_i[DATA_W-1:DIST]};
        MODE_SLL: data_d = {data_i[DATA_W-DIST-1:0], {DIST{1'b0}}};
        MODE_SRL: data_d = {{DIST{1'b0}}, data_i[DATA_W-1:DIST]};
        MODE_SRA: data_d = {{DIST{data_i[DATA_W-1]}}, data_i[DATA_W-1:DIST]};
        default:  data_d = data_i;
      endcase
    end
  end

  // Stage register: loads under global advance, clears on reset. Unused
  // (and optimised away) when the stage is built combinational.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
    end else if (advance_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      amt_q   <= amt_i;
      mode_q  <= mode_i;
    end
  end

  assign valid_o = REG ? valid_q : valid_i;
  assign data_o  = REG ? data_q  : data_d;
  assign amt_o   = REG ? amt_q   : amt_i;
  assign mode_o  = REG ? mode_q  : mode_i;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Purpose: parametrised rotate/shift unit built from log2(DATA_W) shift stages.
// Latency: AMT_W cycles with PIPE = 1, 1 cycle with PIPE = 0.
// Backpressure: global stall; in_ready = ~out_valid | out_ready, all stages hold otherwise.
module barrel_shifter_pipe
  import barrel_shift_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter bit  PIPE   = 1'b1,
  localparam int AMT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  // Inter-stage buses; index 0 is the input port, index AMT_W the output.
  logic [AMT_W:0]              stg_valid;
  logic [AMT_W:0][DATA_W-1:0]  stg_data;
  logic [AMT_W:0][AMT_W-1:0]   stg_amt;
  logic [AMT_W:0][MODE_W-1:0]  stg_mode;

  logic advance;
  logic unused_tail;

  // Whole pipe moves together: it may advance whenever the output slot is
  // empty or being consumed this cycle, so a full pipe still streams.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  assign stg_valid[0] = in_valid;
  assign stg_data[0]  = in_data;
  assign stg_amt[0]   = in_amt;
  assign stg_mode[0]  = in_mode;

  // Stage k shifts by 2^k. Without PIPE only the final stage is registered,
  // giving a single output register behind a combinational shifter.
  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    shift_stage_pipe #(
      .DATA_W (DATA_W),
      .DIST   (1 << k),
      .REG    (PIPE || (k == AMT_W - 1))
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .advance_i (advance),
      .valid_i   (stg_valid[k]),
      .data_i    (stg_data[k]),
      .amt_i     (stg_amt[k]),
      .mode_i    (stg_mode[k]),
      .valid_o   (stg_valid[k+1]),
      .data_o    (stg_data[k+1]),
      .amt_o     (stg_amt[k+1]),
      .mode_o    (stg_mode[k+1])
    );
  end

  assign out_valid = stg_valid[AMT_W];
  assign out_data  = stg_data[AMT_W];

  // Amount and mode leaving the last stage have no consumer.
  assign unused_tail = ^{stg_amt[AMT_W], stg_mode[AMT_W]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Purpose: scoreboard bench for barrel_shifter_pipe (DATA_W = 8).
// Latency: checks 3-cycle (PIPE = 1) or 1-cycle (PIPE = 0) result timing.
// Backpressure: exercises stalls, stable held output and reset flush.
module tb_barrel_shifter_pipe;
  import barrel_shift_pkg::*;

  parameter bit PIPE = 1'b1;
  localparam int LAT   = PIPE ? 3 : 1;
  localparam int NFILL = PIPE ? 3 : 1;

  typedef struct {
    logic [7:0] dat;
    int         hcyc;
    bit         chk;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [2:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         stall_prev = 0;
  logic [7:0] stall_dat = '0;

  barrel_shifter_pipe #(.DATA_W(8), .PIPE(PIPE)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one word, wait (bounded) for acceptance, queue its expected result.
  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [2:0] m,
                      input logic [7:0] e, input bit chk);
    int   n;
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("send_accept", int'(in_ready), 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    x.dat  = e;
    x.hcyc = cyc + 1;
    x.chk  = chk;
    sb.push_back(x);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    #3;
    check(name, sb.size(), 0);
  endtask

  // Monitor: compare every output transfer against the scoreboard and
  // verify handshake/stall rules, sampled mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n) begin
        if (stall_prev) begin
          check("stall_hold_vld", int'(out_valid), 1);
          check("stall_hold_dat", int'(out_data), int'(stall_dat));
        end
        if (out_valid && !out_ready) check("in_rdy_stall", int'(in_ready), 0);
        if (out_ready) check("in_rdy_free", int'(in_ready), 1);
        if (out_valid && out_ready) begin
          check("sb_nonempty", int'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_dat", int'(out_data), int'(e.dat));
            if (e.chk) check("latency", cyc - e.hcyc + 1, LAT);
          end
        end
        stall_prev = out_valid && !out_ready;
        stall_dat  = out_data;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = '0;
    out_ready = 1'b1;

    // Reset state
    #22;
    check("rst_out_vld", int'(out_valid), 0);
    check("rst_out_dat", int'(out_data), 0);
    check("rst_in_rdy",  int'(in_ready), 1);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_vld", int'(out_valid), 0);
    check("post_rst_rdy", int'(in_ready), 1);

    // Directed vectors, hand-computed on 0xD5 = 1101_0101
    send(8'hD5, 3'd2, MODE_ROL, 8'h57, 1'b1);
    idle();
    drain("drain_first");
    send(8'hD5, 3'd1, MODE_ROR, 8'hEA, 1'b1);
    send(8'hD5, 3'd3, MODE_SRA, 8'hFA, 1'b1);
    send(8'hD5, 3'd3, MODE_SRL, 8'h1A, 1'b1);
    send(8'hD5, 3'd7, MODE_SLL, 8'h80, 1'b1);
    send(8'hD5, 3'd5, 3'b101,   8'hD5, 1'b1);
    send(8'hD5, 3'd4, 3'b110,   8'hD5, 1'b1);
    send(8'hD5, 3'd6, 3'b111,   8'hD5, 1'b1);
    send(8'hD5, 3'd1, MODE_SLL, 8'hAA, 1'b1);
    send(8'hD5, 3'd4, MODE_ROL, 8'h5D, 1'b1);
    send(8'hD5, 3'd7, MODE_ROR, 8'hAB, 1'b1);
    send(8'h55, 3'd7, MODE_SRA, 8'h00, 1'b1);
    send(8'h80, 3'd7, MODE_SRA, 8'hFF, 1'b1);
    send(8'h80, 3'd7, MODE_SRL, 8'h01, 1'b1);
    send(8'h01, 3'd7, MODE_ROL, 8'h80, 1'b1);
    for (int m = 0; m < 8; m++) send(8'hD5, 3'd0, 3'(m), 8'hD5, 1'b1);
    idle();
    drain("drain_vectors");

    // Back-to-back walking one, no backpressure
    for (int i = 0; i < 8; i++) send(8'h01, 3'(i), MODE_ROL, 8'(1 << i), 1'b1);
    idle();
    drain("drain_stream");

    // Same stream with a 4-cycle consumer stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) send(8'h01, 3'(i), MODE_ROL, 8'(1 << i), 1'b0);
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Reset with words in flight: everything is discarded
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < NFILL; i++) send(8'(8'h11 * (i + 1)), 3'd1, MODE_ROL, 8'h00, 1'b0);
    #3;
    check("rst_pre_vld", int'(out_valid), 1);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("midrst_vld", int'(out_valid), 0);
    check("midrst_dat", int'(out_data), 0);
    check("midrst_rdy", int'(in_ready), 1);
    sb.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    #3;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    check("rst_no_stale", int'(out_valid), 0);
    send(8'hD5, 3'd2, MODE_ROL, 8'h57, 1'b1);
    idle();
    drain("drain_after_rst");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
